// File: rtl/sic_dispatcher_if.sv
// Dispatcher bus bundle: upstream push handshake, flush, and the per-SIC
// request/packet lanes plus trace outputs.
interface sic_dispatcher_if #(
  parameter int NUM_SICS     = 4,
  parameter int NUM_PHY_REGS = 64,
  parameter int ID_WIDTH     = 8,
  parameter int NUM_ECRS     = 4,
  parameter int DEPTH        = 4
);
  localparam int PRW  = $clog2(NUM_PHY_REGS);
  localparam int ECRW = (NUM_ECRS > 1) ? $clog2(NUM_ECRS) : 1;
  localparam int SW   = (NUM_SICS > 1) ? $clog2(NUM_SICS) : 1;
  localparam int CW   = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic                valid;
    logic [7:0]          opcode;
    logic [ID_WIDTH-1:0] id;
    logic [PRW-1:0]      prd;
    logic [PRW-1:0]      prs1;
    logic [PRW-1:0]      prs2;
    logic [ECRW-1:0]     ecr;
    logic [31:0]         imm;
  } pkt_t;

  logic                     in_valid;
  logic                     in_ready;
  pkt_t                     in_pkt;
  logic                     flush;
  logic [NUM_SICS-1:0]      sic_req_instr;
  pkt_t [NUM_SICS-1:0]      sic_pkt;
  logic                     disp_valid;
  logic [SW-1:0]            disp_sic;
  logic [CW-1:0]            count;

  modport master (output in_valid, in_pkt, flush, sic_req_instr,
                  input  in_ready, sic_pkt, disp_valid, disp_sic, count);
  modport slave  (input  in_valid, in_pkt, flush, sic_req_instr,
                  output in_ready, sic_pkt, disp_valid, disp_sic, count);
endinterface

// File: rtl/sic_dispatcher.sv
// In-order dispatch FIFO feeding an array of SICs; round-robin pick among idle
// SICs, registered one-cycle valid pulse per dispatch, whole-buffer flush.
module sic_disp_lane #(
  parameter int SW    = 2,
  parameter int IDX   = 0,
  parameter int PLD_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             grant_i,
  input  logic             req_i,
  input  logic             out_v_i,
  input  logic             flush_i,
  input  logic [SW-1:0]    tgt_i,
  input  logic [PLD_W-1:0] pld_i,
  output logic             elig_o,
  output logic [PLD_W:0]   pkt_o
);
  logic [1:0] cool_q, cool_d;

  // Two cycles of blackout: one while the packet is on the bus, one while
  // the SIC's req_instr may still read stale-high.
  always_comb begin
    cool_d = cool_q;
    if (grant_i)               cool_d = 2'd2;
    else if (cool_q != 2'd0)   cool_d = cool_q - 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cool_q <= 2'd0;
    else        cool_q <= cool_d;

  assign elig_o = req_i && (cool_q == 2'd0);
  assign pkt_o  = (out_v_i && tgt_i == SW'(IDX)) ? {!flush_i, pld_i} : '0;
endmodule

module sic_dispatcher #(
  parameter int NUM_SICS     = 4,
  parameter int NUM_PHY_REGS = 64,
  parameter int ID_WIDTH     = 8,
  parameter int NUM_ECRS     = 4,
  parameter int DEPTH        = 4
) (
  input logic             clk,
  input logic             rst_n,
  sic_dispatcher_if.slave bus
);
  localparam int PRW  = $clog2(NUM_PHY_REGS);
  localparam int ECRW = (NUM_ECRS > 1) ? $clog2(NUM_ECRS) : 1;
  localparam int SW   = (NUM_SICS > 1) ? $clog2(NUM_SICS) : 1;
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;

  typedef struct packed {
    logic                valid;
    logic [7:0]          opcode;
    logic [ID_WIDTH-1:0] id;
    logic [PRW-1:0]      prd;
    logic [PRW-1:0]      prs1;
    logic [PRW-1:0]      prs2;
    logic [ECRW-1:0]     ecr;
    logic [31:0]         imm;
  } pkt_t;
  localparam int PKT_W = $bits(pkt_t);

  pkt_t                             in_pkt;
  logic                             unused_valid;
  logic [PKT_W-2:0]                 mem_q [DEPTH];
  logic [PW-1:0]                    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]                    count_q;
  logic [SW-1:0]                    rr_q, rr_d, tgt_q, sel, sel_hi, sel_lo;
  logic                             out_v_q;
  logic [PKT_W-2:0]                 out_pld_q;
  logic [NUM_SICS-1:0]              elig;
  logic [NUM_SICS-1:0][PKT_W-1:0]   lane_pkt;
  logic                             in_ready, push, head_ok, found_hi, found_lo, grant;

  // The upstream valid field is payload-only; the handshake is in_valid.
  assign in_pkt       = bus.in_pkt;
  assign unused_valid = in_pkt.valid;

  assign in_ready = (count_q != CW'(DEPTH));
  assign push     = bus.in_valid && in_ready && !bus.flush;
  assign head_ok  = (count_q != '0) && !bus.flush;

  // Round-robin: lowest eligible index at/above rr_q, else lowest below it.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    sel_hi   = '0;
    sel_lo   = '0;
    for (int i = NUM_SICS - 1; i >= 0; i--) begin
      if (elig[i]) begin
        if (SW'(i) >= rr_q) begin
          sel_hi   = SW'(i);
          found_hi = 1'b1;
        end else begin
          sel_lo   = SW'(i);
          found_lo = 1'b1;
        end
      end
    end
  end

  assign sel   = found_hi ? sel_hi : sel_lo;
  assign grant = head_ok && (found_hi || found_lo);
  assign rr_d  = (int'(sel) == NUM_SICS - 1) ? '0 : sel + SW'(1);

  always_ff @(posedge clk)
    if (push) mem_q[wr_ptr_q] <= in_pkt[PKT_W-2:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rr_q      <= '0;
      tgt_q     <= '0;
      out_v_q   <= 1'b0;
      out_pld_q <= '0;
    end else if (bus.flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      out_v_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (grant) begin
        rd_ptr_q  <= rd_ptr_q + PW'(1);
        out_pld_q <= mem_q[rd_ptr_q];
        tgt_q     <= sel;
        rr_q      <= rr_d;
      end
      out_v_q <= grant;
      case ({push, grant})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_SICS; i++) begin : g_lane
    sic_disp_lane #(.SW(SW), .IDX(i), .PLD_W(PKT_W-1)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .grant_i (grant && (sel == SW'(i))),
      .req_i   (bus.sic_req_instr[i]),
      .out_v_i (out_v_q),
      .flush_i (bus.flush),
      .tgt_i   (tgt_q),
      .pld_i   (out_pld_q),
      .elig_o  (elig[i]),
      .pkt_o   (lane_pkt[i])
    );
    assign bus.sic_pkt[i] = lane_pkt[i];
  end

  assign bus.in_ready   = in_ready;
  assign bus.disp_valid = out_v_q && !bus.flush;
  assign bus.disp_sic   = bus.disp_valid ? tgt_q : '0;
  assign bus.count      = count_q;
endmodule

// File: tb/tb_sic_dispatcher.sv
// Bench for sic_dispatcher: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations (incl. a 1-SIC instance).
module tb_sic_dispatcher;
  localparam int N     = 4;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic       valid;
    logic [7:0] opcode;
    logic [7:0] id;
    logic [5:0] prd;
    logic [5:0] prs1;
    logic [5:0] prs2;
    logic [1:0] ecr;
    logic [31:0] imm;
  } pkt_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  sic_dispatcher_if #(.NUM_SICS(N), .DEPTH(DEPTH)) u_if ();
  sic_dispatcher_if #(.NUM_SICS(1), .DEPTH(DEPTH)) u1_if ();

  sic_dispatcher #(.NUM_SICS(N), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(u_if.slave));
  sic_dispatcher #(.NUM_SICS(1), .DEPTH(DEPTH)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(u1_if.slave));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic pkt_t mk(input int n);
    pkt_t p;
    p.valid  = n[0];
    p.opcode = 8'(n + 3);
    p.id     = 8'(n);
    p.prd    = 6'(n);
    p.prs1   = 6'(n + 1);
    p.prs2   = 6'(n + 2);
    p.ecr    = 2'(n);
    p.imm    = 32'(n) * 32'h0101_0101;
    return p;
  endfunction

  // Reference model: packet queue, per-SIC "eligible again at cycle" stamps.
  pkt_t mq[$];
  int   m_until [N];
  int   m_rr, m_tgt, cyc, chosen;
  bit   m_v, m_rdy;
  pkt_t m_pkt, m_in;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_rr = 0; m_tgt = 0; m_v = 0; cyc = 0;
      for (int i = 0; i < N; i++) m_until[i] = 0;
    end else begin
      m_rdy = (mq.size() != DEPTH);
      if (u_if.flush) begin
        mq.delete();
        m_v = 0;
      end else begin
        chosen = -1;
        if (mq.size() != 0)
          for (int k = 0; k < N; k++) begin
            int i;
            i = (m_rr + k) % N;
            if (chosen < 0 && u_if.sic_req_instr[i] && cyc >= m_until[i]) chosen = i;
          end
        if (chosen >= 0) begin
          m_pkt = mq.pop_front();
          m_pkt.valid = 1'b1;
          m_v = 1; m_tgt = chosen;
          m_rr = (chosen + 1) % N;
          m_until[chosen] = cyc + 3;
        end else m_v = 0;
        if (u_if.in_valid && m_rdy) begin
          m_in = u_if.in_pkt;
          mq.push_back(m_in);
        end
      end
      cyc++;
    end
  end

  bit ev;
  always @(negedge clk) if (rst_n) begin
    ev = m_v && !u_if.flush;
    chk("count", u_if.count, mq.size());
    chk("in_ready", u_if.in_ready, mq.size() != DEPTH);
    chk("disp_valid", u_if.disp_valid, ev);
    if (ev) chk("disp_sic", u_if.disp_sic, m_tgt);
    for (int j = 0; j < N; j++) begin
      if (j != m_tgt)  chk("idle_bus", u_if.sic_pkt[j], 0);
      else if (ev)     chk("pulse_pkt", u_if.sic_pkt[j], m_pkt);
      else             chk("tgt_valid", u_if.sic_pkt[j].valid, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_count", u_if.count, 0);
    chk("rst_in_ready", u_if.in_ready, 1);
    chk("rst_disp_valid", u_if.disp_valid, 0);
    chk("rst_disp_sic", u_if.disp_sic, 0);
    chk("rst_sic_pkt", u_if.sic_pkt, 0);
    chk("rst1_sic_pkt", u1_if.sic_pkt, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
  endtask

  int pc [$];
  int pid [$];

  initial begin
    u_if.in_valid = 0; u_if.in_pkt = '0; u_if.flush = 0; u_if.sic_req_instr = '0;
    u1_if.in_valid = 0; u1_if.in_pkt = '0; u1_if.flush = 0; u1_if.sic_req_instr = '0;

    // single packet, all SICs requesting
    do_reset();
    u_if.sic_req_instr = 4'hF;
    u_if.in_valid = 1; u_if.in_pkt = mk(1);
    tick();
    u_if.in_valid = 0;
    chk("t1_count1", u_if.count, 1);
    chk("t1_nopulse", u_if.disp_valid, 0);
    tick();
    chk("t1_count0", u_if.count, 0);
    chk("t1_pulse", u_if.disp_valid, 1);
    chk("t1_sic", u_if.disp_sic, 0);
    chk("t1_id", u_if.sic_pkt[0].id, 1);
    chk("t1_v", u_if.sic_pkt[0].valid, 1);
    tick();
    chk("t1_oneshot", u_if.disp_valid, 0);

    // four back-to-back
    do_reset();
    u_if.sic_req_instr = 4'hF;
    for (int k = 0; k < 6; k++) begin
      u_if.in_valid = (k < 4);
      u_if.in_pkt = mk(10 + k);
      tick();
      chk("t2_in_ready", u_if.in_ready, 1);
      if (k >= 1 && k <= 4) begin
        chk("t2_pulse", u_if.disp_valid, 1);
        chk("t2_sic", u_if.disp_sic, k - 1);
        chk("t2_id", u_if.sic_pkt[k-1].id, 10 + k - 1);
      end
    end
    u_if.in_valid = 0;

    // single SIC: cooldown spacing
    do_reset();
    u1_if.sic_req_instr = 1'b1;
    u1_if.in_valid = 1; u1_if.in_pkt = mk(60);
    for (int c = 0; c < 14; c++) begin
      tick();
      if (u1_if.disp_valid) begin
        pc.push_back(c);
        pid.push_back(int'(u1_if.sic_pkt[0].id));
        chk("t3_sic", u1_if.disp_sic, 0);
      end
      if (c == 0) u1_if.in_pkt = mk(61);
      if (c == 1) u1_if.in_pkt = mk(62);
      if (c == 2) u1_if.in_valid = 0;
    end
    chk("t3_npulses", pc.size(), 3);
    if (pc.size() == 3) begin
      chk("t3_c0", pc[0], 1); chk("t3_c1", pc[1], 4); chk("t3_c2", pc[2], 7);
      chk("t3_id0", pid[0], 60); chk("t3_id1", pid[1], 61); chk("t3_id2", pid[2], 62);
    end
    u1_if.sic_req_instr = 1'b0;

    // fill with no requesters, then release SIC 2
    do_reset();
    u_if.sic_req_instr = 4'h0;
    for (int k = 0; k < 4; k++) begin
      u_if.in_valid = 1; u_if.in_pkt = mk(20 + k);
      tick();
    end
    u_if.in_pkt = mk(99);
    tick();
    chk("t4_full_rdy", u_if.in_ready, 0);
    chk("t4_count4", u_if.count, 4);
    chk("t4_nopulse", u_if.disp_valid, 0);
    u_if.sic_req_instr = 4'b0100;
    tick();
    chk("t4_pulse", u_if.disp_valid, 1);
    chk("t4_sic", u_if.disp_sic, 2);
    chk("t4_id", u_if.sic_pkt[2].id, 20);
    chk("t4_rdy_back", u_if.in_ready, 1);
    chk("t4_count3", u_if.count, 3);
    u_if.in_valid = 0;
    u_if.sic_req_instr = 4'hF;
    repeat (10) tick();
    chk("t4_drained", u_if.count, 0);

    // flush during a pulse
    do_reset();
    u_if.sic_req_instr = 4'h0;
    for (int k = 0; k < 3; k++) begin
      u_if.in_valid = 1; u_if.in_pkt = mk(30 + k);
      tick();
    end
    u_if.in_valid = 0;
    u_if.sic_req_instr = 4'b0001;
    tick();
    chk("t5_pulse", u_if.disp_valid, 1);
    chk("t5_count2", u_if.count, 2);
    u_if.flush = 1; u_if.in_valid = 1; u_if.in_pkt = mk(40);
    #1;
    chk("t5_masked", u_if.disp_valid, 0);
    chk("t5_masked_v", u_if.sic_pkt[0].valid, 0);
    tick();
    u_if.flush = 0; u_if.in_valid = 0;
    chk("t5_count0", u_if.count, 0);
    chk("t5_rdy", u_if.in_ready, 1);
    chk("t5_nopulse", u_if.disp_valid, 0);
    u_if.sic_req_instr = 4'hF;
    repeat (4) tick();
    chk("t5_still0", u_if.count, 0);

    // async reset with a live pulse
    do_reset();
    u_if.sic_req_instr = 4'h0;
    for (int k = 0; k < 4; k++) begin
      u_if.in_valid = 1; u_if.in_pkt = mk(50 + k);
      tick();
    end
    u_if.in_valid = 0;
    u_if.sic_req_instr = 4'b0001;
    tick();
    chk("t6_pulse", u_if.disp_valid, 1);
    chk("t6_count3", u_if.count, 3);
    do_reset();
    chk("t6_rdy", u_if.in_ready, 1);
    chk("t6_count0", u_if.count, 0);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/sic_dispatcher.md
# sic_dispatcher

In-order dispatch buffer between the issue/rename front end and the array of `single_instruction_controller` instances. It accepts renamed `sic_packet` words from upstream over a valid/ready handshake and holds them in a small FIFO. It hands each head packet to exactly one idle SIC, selected round-robin among SICs asserting `req_instr`, as a registered one-cycle `valid` pulse. It also provides a whole-buffer flush for PC redirects.

## Interface
Parameters:
- `NUM_SICS`, 4: number of SICs served; ≥1.
- `NUM_PHY_REGS`, 64: forwarded to the `sic_packet` type.
- `ID_WIDTH`, 8: forwarded to the `sic_packet` type.
- `NUM_ECRS`, 4: forwarded to the `sic_packet` type.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.

Ports (`pkt_t` = `sic_packet#(NUM_PHY_REGS, ID_WIDTH, NUM_ECRS)::t`):
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream offers `in_pkt`.
- `in_ready`  out  1  buffer can accept; equals `count != DEPTH`.
- `in_pkt`  in  pkt_t  packet; its `.valid` field is ignored and rewritten on output.
- `flush`  in  1  discard all buffered and in-flight-to-SIC packets.
- `sic_req_instr`  in  NUM_SICS  per-SIC "idle, wants instruction".
- `sic_pkt`  out  pkt_t [NUM_SICS]  per-SIC packet bus; `.valid` is the dispatch pulse.
- `disp_valid`  out  1  trace: a `sic_pkt` pulse is active this cycle.
- `disp_sic`  out  $clog2(NUM_SICS) (min 1)  trace: index of the pulsed SIC.
- `count`  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- FIFO: circular, with `wr_ptr`, `rd_ptr` and `count` registers. A push occurs on `in_valid && in_ready && !flush`. Pointers wrap modulo DEPTH.
- Selection in cycle t:
  - `head_ok = count != 0 && !flush`.
  - `eligible[i] = sic_req_instr[i] && !cool[i]`.
  - Scan starts at `rr_ptr` and wraps; the first eligible SIC is chosen.
  - If `head_ok` and a SIC is chosen: pop the head; at the t edge load the output register with {packet, valid=1, target=i}; `rr_ptr <= i+1 mod NUM_SICS`; set `cool[i]` for 2 cycles.
- Output, cycle t+1:
  - `sic_pkt[target] = held packet` with `.valid = out_v && !flush`.
  - Every other `sic_pkt[j]` is all-zero.
  - `disp_valid` and `disp_sic` mirror `sic_pkt[target].valid` and the target index.
- Otherwise `out_v <= 0`.
- Cooldown: `cool[i]` is a 2-bit down-counter loaded with 2 on grant. SIC i is ineligible during t+1 (packet on bus) and t+2 (its `req_instr` is not yet guaranteed low). Its earliest next selection is t+3.
- Order: strictly FIFO. At most one dispatch per cycle. A packet never skips the head.
- Push and pop in the same cycle: `count` is unchanged.
- `in_ready` is derived only from registered `count`; a pop does not make room in the same cycle.
- Flush, on a cycle with `flush=1`:
  - The current `sic_pkt` pulse is masked.
  - At the edge: `count`/`wr_ptr`/`rd_ptr` are cleared, `out_v` is cleared, no push and no pop occur.
  - `rr_ptr` and `cool` are kept.
- The `in_pkt.valid` field is never used as the handshake.

## Timing
- Reset (async assert): `count=0`, pointers=0, `rr_ptr=0`, `cool=0`, `out_v=0`. Consequently `sic_pkt` is all-zero, `disp_valid=0`, `disp_sic=0`, and `in_ready=1`.
- Reset mid-operation discards everything, including a pulse currently on the bus.
- Latency: a push at edge e reaches a SIC no earlier than the pulse in cycle e+2. This is one cycle of FIFO presence, which is selectable, plus the registered output. There is no bypass.
- Full: `in_ready=0` at `count==DEPTH`. It returns to 1 the cycle after the first pop.
- Empty: no selection, and `out_v` falls the next cycle.
- No eligible SIC: the head waits, and `rr_ptr` is unchanged.
- The pulse lasts exactly one cycle. A SIC whose `req_instr` drops while a pulse is on its bus still receives it; correctness relies on that SIC latching the packet.

## Test plan
- Push one packet with all 4 SICs requesting → pulse on `sic_pkt[0]` exactly 2 cycles after the push edge, `disp_sic=0`; `count` goes 1→0.
- Push 4 packets back-to-back, all SICs always requesting → pulses to SICs 0,1,2,3 in consecutive cycles, in push order; `in_ready` never drops.
- `NUM_SICS=1`, SIC always requesting, 3 packets queued → pulses spaced 3 cycles apart (cooldown); no double-dispatch.
- Fill 4 with all `sic_req_instr=0` → `in_ready=0`, `count=4`, no pulses. Raise `sic_req_instr[2]` → next pulse targets SIC 2, and `in_ready` returns to 1 one cycle after the pop.
- Assert `flush` during a pulse cycle with 2 entries queued → the pulse is masked to `valid=0`; next cycle `count=0` and no further pulses; a push in the flush cycle is dropped.
- Assert `rst_n=0` asynchronously while `count=3` and a pulse is live → all outputs zero immediately; after release `in_ready=1` and `count=0`.
